// File: rtl/mem_pkg.sv
// Shared memory-side definitions: FSM encoding and cache line geometry.
// The cache management unit reuses these.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = 16;

  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

  function automatic logic [31:0] line_base(
    input logic [31:0] a
  );
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/line_ram_ram_array.sv
// Single-port synchronous word array.
// Registered read with old-data read-during-write.
module ram_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   din,
  output logic [31:0]   dout
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout <= mem[addr];
  end

endmodule

// File: rtl/line_ram.sv
// Line-burst main memory model: one cs per 16-byte line,
// programmable latency, then four acked word beats.
module line_ram
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        ack,
  output logic        busy,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  state_t        state;
  logic [3:0]    lat;
  logic [1:0]    beat;
  logic          wr;
  logic [AW-1:0] base;

  logic [31:0]   line;
  logic          unused_bits;
  logic          rd_ahead;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_dout;
  logic [31:0]   hold;

  assign line        = line_base(addr);
  assign unused_bits = ^{line[31:AW+2], line[1:0]};

  // Reads run one word ahead so the registered array
  // output lines up with the ack cycle of each beat.
  assign rd_ahead = (state == S_BURST) && !wr;
  assign ram_addr = base + AW'(beat) + AW'(rd_ahead);
  assign ram_we   = (state == S_BURST) && wr && rst_n;

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      lat   <= '0;
      beat  <= '0;
      wr    <= 1'b0;
      base  <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (cs) begin
            state <= S_WAIT;
            busy  <= 1'b1;
            wr    <= we;
            base  <= line[AW+1:2];
            lat   <= 4'(LATENCY - 1);
            beat  <= '0;
          end
        end
        S_WAIT: begin
          if (lat == '0) begin
            state <= S_BURST;
            ack   <= 1'b1;
            beat  <= '0;
          end else begin
            lat <= lat - 4'd1;
          end
        end
        S_BURST: begin
          beat <= beat + 2'd1;
          if (beat == 2'(LINE_WORDS - 1)) begin
            state <= S_IDLE;
            ack   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (ack && !wr) begin
      hold <= ram_dout;
    end
  end

  assign dout = (ack && !wr) ? ram_dout : hold;

endmodule

// File: tb/tb_line_ram.sv
// Directed bench for line_ram with a read-data scoreboard.
module tb_line_ram;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        ack;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb [$];
  logic [31:0] pat [4];

  line_ram #(
    .DEPTH   (1024),
    .LATENCY (L)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .ack   (ack),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in the cycle where cs is driven; ends in the done cycle.
  task automatic burst(
    input logic        w,
    input logic [31:0] a,
    input logic [31:0] d [4],
    input logic [15:0] stray
  );
    logic [31:0] e;
    int acks;
    int dones;
    acks  = 0;
    dones = 0;
    if (!w) begin
      for (int i = 0; i < 4; i++) sb.push_back(d[i]);
    end
    cs   = 1'b1;
    we   = w;
    addr = a;
    tick();
    cs = 1'b0;
    for (int c = 1; c <= L + 5; c++) begin
      cs = stray[c];
      if (w && c >= L + 1 && c <= L + 4) din = d[c-L-1];
      acks  += int'(ack);
      dones += int'(done);
      check("busy", 32'(busy), 32'(c <= L + 4));
      check("ack", 32'(ack), 32'(c >= L + 1 && c <= L + 4));
      check("done", 32'(done), 32'(c == L + 5));
      if (ack && !w) begin
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("rd_data", dout, e);
        end
      end
      if (c == L + 5 && !w) check("dout_hold", dout, d[3]);
      if (c < L + 5) tick();
    end
    cs = 1'b0;
    check("ack_count", 32'(acks), 32'd4);
    check("done_count", 32'(dones), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    cs    = 1'b0;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    tick();
    tick();
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dout", dout, 32'd0);
    rst_n = 1'b1;
    tick();

    pat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    burst(1'b1, 32'h0000_0040, pat, 16'h0);
    tick();
    burst(1'b0, 32'h0000_0040, pat, 16'h0);
    tick();
    burst(1'b0, 32'h0000_004C, pat, 16'h0);
    tick();
    burst(1'b0, 32'h0000_1040, pat, 16'h0);
    tick();

    // stray cs in cycles 2 and 5 must be dropped
    burst(1'b0, 32'h0000_0040, pat, 16'b0000_0000_0010_0100);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_second_busy", 32'(busy), 32'd0);
      check("no_second_ack", 32'(ack), 32'd0);
    end

    // back-to-back: second cs lands in the done cycle
    pat = '{32'h11, 32'h12, 32'h13, 32'h14};
    burst(1'b1, 32'h0000_0080, pat, 16'h0);
    pat = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    burst(1'b0, 32'h0000_0040, pat, 16'h0);
    tick();

    // reset during beat 2 of a write burst
    pat = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    cs   = 1'b1;
    we   = 1'b1;
    addr = 32'h0000_0080;
    tick();
    cs = 1'b0;
    for (int c = 1; c <= L + 2; c++) begin
      if (c >= L + 1) din = pat[c-L-1];
      tick();
    end
    check("pre_rst_ack", 32'(ack), 32'd1);
    din   = pat[2];
    rst_n = 1'b0;
    tick();
    check("abort_dout", dout, 32'd0);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_done", 32'(done), 32'd0);
    pat = '{32'hB0, 32'hB1, 32'h13, 32'h14};
    burst(1'b0, 32'h0000_0080, pat, 16'h0);
    tick();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_ram.md
# line_ram

Main-memory model that sits directly downstream of the cache management unit and serves whole 16-byte cache lines as 4-beat bursts. A line request is accepted with a single `cs` strobe. After a programmable access latency, four word beats are delivered (read) or absorbed (write), each marked by a one-cycle `ack`. `busy` is the stall source the cache controller waits on, and `done` marks burst completion.

## Interface
- `DEPTH`, 1024: storage size in 32-bit words; power of two.
- `LATENCY`, 3: idle cycles between request accept and first beat; legal range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cs` in 1: request strobe; sampled only when `busy`=0.
- `we` in 1: 1 = line write, 0 = line read; sampled with `cs`.
- `addr` in 32: byte address; bits [3:0] ignored (line-aligned); captured at accept.
- `din` in 32: write beat data; must be valid in every cycle where `ack`=1 during a write burst.
- `dout` out 32: read beat data; valid only while `ack`=1 during a read burst.
- `ack` out 1: beat strobe, one per word, four per burst.
- `busy` out 1: burst in progress; `cs` is ignored while high.
- `done` out 1: one-cycle pulse in the first cycle after the last beat.

## Operation
- Reset (`rst_n`=0 at an edge): state=IDLE; `dout`=0, `ack`=0, `busy`=0, `done`=0; beat and latency counters cleared. Array contents are not cleared.
- States:
  - IDLE: waits for `cs`.
  - WAIT: counts down `LATENCY` cycles.
  - BURST: emits beats 0..3.
  - IDLE again, with `done` pulsed.
- IDLE -> WAIT when `cs`=1 at an edge. Captured at that edge: `we`, line base = {`addr`[31:4],4'b0}, latency counter = `LATENCY`-1.
- WAIT: decrements each cycle. At the edge where the counter is 0 -> BURST, beat=0.
- BURST, per beat k (0..3):
  - Word address = (line base >> 2) + k, modulo `DEPTH`.
  - Read: `dout` = array[word] and `ack`=1 in the same cycle.
  - Write: array[word] <= `din` at the edge closing the `ack` cycle.
  - After k=3 -> IDLE with `done`=1 for one cycle.
- Beat counter is 2 bits and wraps 3 -> 0 on burst exit.
- Out-of-range addresses alias modulo `DEPTH`, with no error indication.
- `cs` while `busy`=1 is dropped, not queued. The requester must re-strobe after `done`.
- `cs` in the `done` cycle is accepted: back-to-back bursts, no dead cycle.
- Reset mid-burst aborts immediately.
  - Already-written beats of a write burst remain in the array; unwritten beats keep their old values.
  - No `done` is issued.

## Timing
- Cycle 0: `cs`=1, accepted at its closing edge.
- `busy`=1 in cycles 1 .. `LATENCY`+4.
- `ack`=1 in cycles `LATENCY`+1 .. `LATENCY`+4: beats 0..3, contiguous, no gaps.
- `done`=1 and `busy`=0 in cycle `LATENCY`+5. A new `cs` may be accepted there.
- Total occupancy `LATENCY`+5 cycles per line; at default latency 3: 8 cycles per line.
- Read `dout` is registered, so the array read happens one cycle before the `ack` cycle.
- `dout` holds its last value outside `ack` cycles.
- Write of a beat is visible to a read burst accepted at or after its `done` cycle.

## Structure
- Shared package `mem_pkg`:
  - State encoding constants S_IDLE/S_WAIT/S_BURST (2 bits).
  - `LINE_WORDS`=4, `LINE_BYTES`=16.
  - Line-align helper constant `LINE_MASK`=32'hFFFF_FFF0.
  - Intended for reuse by the cache management unit.
- One sub-module: `ram_array`, a single-port synchronous word array with inputs `clk`, `we`, word address, `din` and registered output `dout`; parameterised by `DEPTH`.
- The controller (FSM, counters, address generation) lives in `line_ram`.

## Test plan
- Write line 0x0000_0040 with din = 0xA0, 0xA1, 0xA2, 0xA3 on the four ack cycles, then read 0x0000_0040 -> ack cycles 4..7 after the read accept return 0xA0..0xA3 in order; done in cycle 8.
- Read with addr=0x0000_004C (unaligned) -> identical data to 0x40; beat order starts at word 0x40, not 0x4C.
- `cs` pulsed in cycles 2 and 5 of a busy burst -> ignored; exactly 4 acks and 1 done; no second burst.
- Back-to-back: second `cs` in the done cycle -> second burst's first ack exactly `LATENCY`+1 cycles later; `busy` low for only that one cycle.
- `rst_n`=0 after beat 1 of a write of 0xB0..0xB3 over a line holding 0x11..0x14 -> outputs all 0 next cycle; readback gives 0xB0, 0xB1, 0x13, 0x14.
- DEPTH=1024, read addr 0x0000_1040 -> aliases to word 0x10: returns line 0x40 contents.
